// File: rtl/branch_predictor_if.sv
// Fetch-side predictor bus: IF lookup, MEM resolution feedback and the mispredict counter.
interface branch_predictor_if #(
    parameter int unsigned CNT_W = 16
);
    logic [31:0]      lookup_pc;
    logic             pred_taken;
    logic [31:0]      pred_offset;
    logic             upd_valid;
    logic [31:0]      upd_pc;
    logic             upd_taken;
    logic [31:0]      upd_offset;
    logic             upd_mispredict;
    logic [CNT_W-1:0] mispredict_cnt;

    modport master (
        output lookup_pc, upd_valid, upd_pc, upd_taken, upd_offset, upd_mispredict,
        input  pred_taken, pred_offset, mispredict_cnt
    );

    modport slave (
        input  lookup_pc, upd_valid, upd_pc, upd_taken, upd_offset, upd_mispredict,
        output pred_taken, pred_offset, mispredict_cnt
    );
endinterface

// File: rtl/branch_predictor.sv
// Direct-mapped direction/target predictor: 2-bit saturating counters plus PC-relative offsets,
// combinational lookup from registered state, single-entry training per cycle.
module branch_predictor #(
    parameter int unsigned INDEX_W = 6,
    parameter int unsigned TAG_W   = 8,
    parameter int unsigned CNT_W   = 16
) (
    input logic               clk,
    input logic               rst,
    branch_predictor_if.slave bp
);
    localparam int unsigned ENTRIES = 1 << INDEX_W;
    localparam int unsigned TAG_LO  = INDEX_W + 2;
    localparam int unsigned TAG_HI  = INDEX_W + TAG_W + 1;

    logic [ENTRIES-1:0]            valid_q, valid_d;
    logic [ENTRIES-1:0][1:0]       ctr_q, ctr_d;
    logic [ENTRIES-1:0][TAG_W-1:0] tag_q, tag_d;
    logic [ENTRIES-1:0][31:0]      off_q, off_d;
    logic [CNT_W-1:0]              cnt_q, cnt_d;

    logic [INDEX_W-1:0] lk_idx, up_idx;
    logic [TAG_W-1:0]   lk_tag, up_tag;
    logic               lk_hit, up_hit, upd_en;

    assign lk_idx = bp.lookup_pc[TAG_LO-1:2];
    assign lk_tag = bp.lookup_pc[TAG_HI:TAG_LO];
    assign up_idx = bp.upd_pc[TAG_LO-1:2];
    assign up_tag = bp.upd_pc[TAG_HI:TAG_LO];

    // Address bits outside index/tag do not participate in prediction.
    logic unused_pc_bits;
    assign unused_pc_bits = ^{bp.lookup_pc[31:TAG_HI+1], bp.lookup_pc[1:0],
                              bp.upd_pc[31:TAG_HI+1], bp.upd_pc[1:0]};

    // Lookup sees pre-update state; reset forces a not-taken prediction.
    assign lk_hit            = valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);
    assign bp.pred_taken     = lk_hit && ctr_q[lk_idx][1] && !rst;
    assign bp.pred_offset    = bp.pred_taken ? off_q[lk_idx] : 32'd0;
    assign bp.mispredict_cnt = cnt_q;

    assign upd_en = bp.upd_valid && !rst;
    assign up_hit = valid_q[up_idx] && (tag_q[up_idx] == up_tag);

    // Training: hit adjusts counter, taken miss/alias (re)allocates weakly taken.
    always_comb begin
        valid_d = valid_q;
        ctr_d   = ctr_q;
        tag_d   = tag_q;
        off_d   = off_q;
        cnt_d   = cnt_q;
        if (upd_en) begin
            if (up_hit) begin
                if (bp.upd_taken) begin
                    if (ctr_q[up_idx] != 2'b11) begin
                        ctr_d[up_idx] = ctr_q[up_idx] + 2'b01;
                    end
                    off_d[up_idx] = bp.upd_offset;
                end else if (ctr_q[up_idx] != 2'b00) begin
                    ctr_d[up_idx] = ctr_q[up_idx] - 2'b01;
                end
            end else if (bp.upd_taken) begin
                valid_d[up_idx] = 1'b1;
                tag_d[up_idx]   = up_tag;
                ctr_d[up_idx]   = 2'b10;
                off_d[up_idx]   = bp.upd_offset;
            end
            if (bp.upd_mispredict && (cnt_q != {CNT_W{1'b1}})) begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= '0;
            ctr_q   <= {ENTRIES{2'b01}};
            cnt_q   <= '0;
        end else begin
            valid_q <= valid_d;
            ctr_q   <= ctr_d;
            cnt_q   <= cnt_d;
        end
    end

    // Tags and offsets are qualified by valid, so they carry no reset.
    always_ff @(posedge clk) begin
        tag_q <= tag_d;
        off_q <= off_d;
    end
endmodule

// File: tb/tb_branch_predictor.sv
// Directed scenarios plus randomized traffic against an entry-level reference model of the predictor.
module tb_branch_predictor;
    localparam int unsigned INDEX_W = 6;
    localparam int unsigned TAG_W   = 8;
    localparam int unsigned CNT_W   = 10;
    localparam int unsigned ENTRIES = 1 << INDEX_W;
    localparam int unsigned CNT_MAX = (1 << CNT_W) - 1;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    branch_predictor_if #(.CNT_W(CNT_W)) bp_if ();

    branch_predictor #(.INDEX_W(INDEX_W), .TAG_W(TAG_W), .CNT_W(CNT_W)) dut (
        .clk (clk),
        .rst (rst),
        .bp  (bp_if.slave)
    );

    // Reference model: one record per table slot, counter as a plain integer 0..3.
    bit          m_valid [ENTRIES];
    int unsigned m_tag   [ENTRIES];
    int          m_ctr   [ENTRIES];
    logic [31:0] m_off   [ENTRIES];
    int unsigned m_cnt;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    function automatic int unsigned idx_of(input logic [31:0] pc);
        return (pc >> 2) % ENTRIES;
    endfunction

    function automatic int unsigned tag_of(input logic [31:0] pc);
        return (pc >> (2 + INDEX_W)) % (1 << TAG_W);
    endfunction

    task automatic model_reset();
        for (int i = 0; i < ENTRIES; i++) begin
            m_valid[i] = 1'b0;
            m_ctr[i]   = 1;
        end
        m_cnt = 0;
    endtask

    task automatic model_update(input logic [31:0] upc, input bit ut, input logic [31:0] uoff, input bit um);
        int unsigned i;
        i = idx_of(upc);
        if (m_valid[i] && m_tag[i] == tag_of(upc)) begin
            if (ut) begin
                m_ctr[i] = (m_ctr[i] + 1 > 3) ? 3 : m_ctr[i] + 1;
                m_off[i] = uoff;
            end else begin
                m_ctr[i] = (m_ctr[i] - 1 < 0) ? 0 : m_ctr[i] - 1;
            end
        end else if (ut) begin
            m_valid[i] = 1'b1;
            m_tag[i]   = tag_of(upc);
            m_ctr[i]   = 2;
            m_off[i]   = uoff;
        end
        if (um && m_cnt < CNT_MAX) m_cnt++;
    endtask

    // One clock: drive at negedge, check combinational outputs, then advance the model at posedge.
    task automatic cyc(input string tag, input bit r, input logic [31:0] lpc,
                       input bit uv, input logic [31:0] upc, input bit ut,
                       input logic [31:0] uoff, input bit um);
        int unsigned i;
        bit          exp_t;
        rst                   = r;
        bp_if.lookup_pc       = lpc;
        bp_if.upd_valid       = uv;
        bp_if.upd_pc          = upc;
        bp_if.upd_taken       = ut;
        bp_if.upd_offset      = uoff;
        bp_if.upd_mispredict  = um;
        #1;
        i     = idx_of(lpc);
        exp_t = !r && m_valid[i] && (m_tag[i] == tag_of(lpc)) && (m_ctr[i] >= 2);
        check_eq({tag, "_taken"}, 32'(bp_if.pred_taken), 32'(exp_t));
        check_eq({tag, "_offset"}, bp_if.pred_offset, exp_t ? m_off[i] : 32'd0);
        check_eq({tag, "_cnt"}, 32'(bp_if.mispredict_cnt), m_cnt);
        @(posedge clk);
        if (r) model_reset();
        else if (uv) model_update(upc, ut, uoff, um);
        @(negedge clk);
    endtask

    task automatic look(input string tag, input logic [31:0] lpc);
        cyc(tag, 1'b0, lpc, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0);
    endtask

    task automatic upd(input string tag, input logic [31:0] pc, input bit ut, input logic [31:0] off, input bit um);
        cyc(tag, 1'b0, pc, 1'b1, pc, ut, off, um);
    endtask

    initial begin
        logic [31:0] alias_pc;
        logic [31:0] lpc, upc;
        rst = 1'b1;
        bp_if.lookup_pc      = 32'd0;
        bp_if.upd_valid      = 1'b0;
        bp_if.upd_pc         = 32'd0;
        bp_if.upd_taken      = 1'b0;
        bp_if.upd_offset     = 32'd0;
        bp_if.upd_mispredict = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);

        // T1: clean state after reset
        look("t1", 32'h40);
        check_eq("t1_cnt_zero", 32'(bp_if.mispredict_cnt), 32'd0);

        // T2: taken allocation becomes visible next cycle
        upd("t2_upd", 32'h40, 1'b1, 32'h20, 1'b1);
        look("t2_look", 32'h40);
        check_eq("t2_taken_const", 32'(bp_if.pred_taken), 32'd1);
        check_eq("t2_off_const", bp_if.pred_offset, 32'h20);
        check_eq("t2_cnt_const", 32'(bp_if.mispredict_cnt), 32'd1);

        // T3: saturate up, then walk down through the threshold and floor
        repeat (3) upd("t3_up", 32'h40, 1'b1, 32'h24, 1'b0);
        look("t3_sat", 32'h40);
        upd("t3_nt1", 32'h40, 1'b0, 32'h0, 1'b0);
        look("t3_after_nt1", 32'h40);
        check_eq("t3_still_taken", 32'(bp_if.pred_taken), 32'd1);
        upd("t3_nt2", 32'h40, 1'b0, 32'h0, 1'b1);
        look("t3_after_nt2", 32'h40);
        check_eq("t3_now_not_taken", 32'(bp_if.pred_taken), 32'd0);
        repeat (2) upd("t3_floor", 32'h40, 1'b0, 32'h0, 1'b0);
        upd("t3_up_from_floor", 32'h40, 1'b1, 32'h28, 1'b0);
        look("t3_floor_check", 32'h40);
        check_eq("t3_floor_was_00", 32'(bp_if.pred_taken), 32'd0);

        // T4: alias replaces the entry
        repeat (2) upd("t4_train", 32'h40, 1'b1, 32'h30, 1'b0);
        alias_pc = 32'h40 + (32'd4 << INDEX_W);
        look("t4_alias_look", alias_pc);
        upd("t4_alias_upd", alias_pc, 1'b1, 32'hFFFF_FFF0, 1'b1);
        look("t4_alias_hit", alias_pc);
        look("t4_orig_miss", 32'h40);
        check_eq("t4_orig_miss_const", 32'(bp_if.pred_taken), 32'd0);

        // T5: same-cycle lookup returns pre-update contents
        cyc("t5_same", 1'b0, 32'h80, 1'b1, 32'h80, 1'b1, 32'h44, 1'b0);
        look("t5_next", 32'h80);
        check_eq("t5_next_const", 32'(bp_if.pred_taken), 32'd1);

        // Mispredict strobe without upd_valid is ignored
        cyc("ign_mp", 1'b0, 32'h80, 1'b0, 32'h80, 1'b1, 32'h0, 1'b1);

        // T6: reset with a pending update, then counter saturation
        for (int k = 0; k < 4; k++) upd("t6_train", 32'h100 + 32'(k * 4), 1'b1, 32'(k * 8 + 8), 1'b1);
        cyc("t6_rst", 1'b1, 32'h100, 1'b1, 32'h10C, 1'b1, 32'h50, 1'b1);
        for (int k = 0; k < 4; k++) look("t6_miss", 32'h100 + 32'(k * 4));
        for (int k = 0; k < (1 << CNT_W) + 3; k++)
            cyc("t6_mp", 1'b0, 32'h200, 1'b1, 32'h300, 1'b0, 32'h0, 1'b1);
        check_eq("t6_cnt_sat", 32'(bp_if.mispredict_cnt), 32'(CNT_MAX));

        // Randomized traffic on a small address pool to force hits, aliases and counter movement
        for (int k = 0; k < 1500; k++) begin
            lpc = ($urandom << 16) | (32'($urandom_range(0, 2)) << (INDEX_W + 2))
                | (32'($urandom_range(0, 7)) << 2) | 32'($urandom_range(0, 3));
            upc = ($urandom << 16) | (32'($urandom_range(0, 2)) << (INDEX_W + 2))
                | (32'($urandom_range(0, 7)) << 2) | 32'($urandom_range(0, 3));
            if ($urandom_range(0, 3) == 0) upc = lpc;
            cyc("rand", ($urandom_range(0, 63) == 0), lpc, 1'($urandom_range(0, 1)), upc,
                1'($urandom_range(0, 1)), $urandom, 1'($urandom_range(0, 1)));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
